// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// ALU operations and the PC / register-destination selects.
package mcpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:         return ALU_SUB;
            OP_SLL:         return ALU_SLL;
            OP_OR, OP_ORI:  return ALU_OR;
            OP_AND:         return ALU_AND;
            OP_SLT:         return ALU_SLT;
            default:        return ALU_ADD;
        endcase
    endfunction

    function automatic logic sign_ext_of(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control decode: current state, opcode and ALU zero flag to
// every datapath control of the multicycle CPU.
module control_decode
    import mcpu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [2:0]      state,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            ExtSel,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegData,
    output logic            DBDataSrc,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            DataMemRW,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUOp
);

    state_t     st;
    logic [5:0] op;

    assign st       = state_t'(state);
    assign op       = opcode[5:0];
    assign InsMemRW = 1'b1;

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = RD_RA;
        WrRegData = 1'b0;
        DBDataSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        DataMemRW = 1'b0;
        PCSrc     = PC_NEXT;
        ALUOp     = ALU_ADD;

        // The IR is still loading during fetch, so the extender select only
        // follows the opcode once decode has begun.
        if (st != S_IF) ExtSel = sign_ext_of(op);

        case (st)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                case (op)
                    OP_J: begin
                        PCWre = 1'b1;
                        PCSrc = PC_JUMP;
                    end
                    OP_JR: begin
                        PCWre = 1'b1;
                        PCSrc = PC_RS;
                    end
                    OP_JAL: begin
                        PCWre  = 1'b1;
                        PCSrc  = PC_JUMP;
                        RegWre = 1'b1;
                        RegDst = RD_RA;
                    end
                    default: ;
                endcase
            end
            S_EXE_AL, S_WB_AL: begin
                ALUSrcA = (op == OP_SLL);
                ALUSrcB = (op == OP_ADDI) || (op == OP_ORI);
                ALUOp   = alu_op_of(op);
                if (st == S_WB_AL) begin
                    RegWre    = 1'b1;
                    WrRegData = 1'b1;
                    PCWre     = 1'b1;
                    RegDst    = ((op == OP_ADDI) || (op == OP_ORI)) ? RD_RT : RD_RD;
                end
            end
            S_EXE_LS: ALUSrcB = 1'b1;
            S_MEM: begin
                ALUSrcB = 1'b1;
                if (op == OP_SW) begin
                    DataMemRW = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            S_WB_L: begin
                ALUSrcB   = 1'b1;
                RegWre    = 1'b1;
                RegDst    = RD_RT;
                WrRegData = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
            end
            S_EXE_BR: begin
                ALUOp = ALU_SUB;
                PCWre = 1'b1;
                PCSrc = zero ? PC_BRANCH : PC_NEXT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU controller: instruction-phase state register and next-state
// logic, with output decode delegated to control_decode.
module multicycle_control_unit
    import mcpu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic [2:0]      state,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            ExtSel,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegData,
    output logic            DBDataSrc,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            DataMemRW,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUOp
);

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] op;

    assign op    = opcode[5:0];
    assign state = cur_state;

    always_ff @(posedge CLK) begin
        if (Reset) cur_state <= S_IF;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IF: nxt_state = S_ID;
            S_ID: begin
                // Halt and any unrecognised opcode simply keep decode looping.
                if (is_alu_op(op))                            nxt_state = S_EXE_AL;
                else if ((op == OP_SW) || (op == OP_LW))      nxt_state = S_EXE_LS;
                else if (op == OP_BEQ)                        nxt_state = S_EXE_BR;
                else if ((op == OP_J) || (op == OP_JR) || (op == OP_JAL))
                                                              nxt_state = S_IF;
                else                                          nxt_state = S_ID;
            end
            S_EXE_AL: nxt_state = S_WB_AL;
            S_WB_AL:  nxt_state = S_IF;
            S_EXE_BR: nxt_state = S_IF;
            S_EXE_LS: nxt_state = S_MEM;
            S_MEM:    nxt_state = (op == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:   nxt_state = S_IF;
            default:  nxt_state = S_IF;
        endcase
    end

    control_decode #(.OP_W(OP_W)) u_decode (
        .state     (cur_state),
        .opcode    (opcode),
        .zero      (zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .ExtSel    (ExtSel),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegData (WrRegData),
        .DBDataSrc (DBDataSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .DataMemRW (DataMemRW),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp)
    );

endmodule
